// File: rtl/cell_array_seq_if.sv
// cell_array_seq_if: host-side config/run handshake bundle for cell_array_seq.
interface cell_array_seq_if #(
  parameter int DIMX        = 64,
  parameter int PORT_WIDTH  = 32,
  parameter int COUNTER_BIT = 16
);
  logic                   cfg_start;
  logic                   cfg_valid;
  logic [PORT_WIDTH-1:0]  cfg_data;
  logic                   cfg_ready;
  logic                   cfg_done;
  logic                   run_start;
  logic [COUNTER_BIT-1:0] run_cycles;
  logic [DIMX-1:0]        io_in;
  logic                   abort;
  logic                   busy;
  logic                   run_done;
  logic [DIMX-1:0]        io_out;
  logic [PORT_WIDTH-1:0]  cfg_sum;
  modport master (
    output cfg_start, cfg_valid, cfg_data, run_start, run_cycles, io_in, abort,
    input  cfg_ready, cfg_done, busy, run_done, io_out, cfg_sum
  );
  modport slave (
    input  cfg_start, cfg_valid, cfg_data, run_start, run_cycles, io_in, abort,
    output cfg_ready, cfg_done, busy, run_done, io_out, cfg_sum
  );
endinterface

// File: rtl/cell_array_seq.sv
// cell_array_seq: streams config words into a cell array, runs it for a counted number of
// clock-enabled cycles and snapshots its output; CELL_SEQ_CHECKSUM_EN adds a config checksum.
module cell_array_seq #(
  parameter int DIMX        = 64,
  parameter int DIMY        = 64,
  parameter int PORT_WIDTH  = 32,
  parameter int CELL_BITS   = 4,
  parameter int COUNTER_BIT = 16,
  parameter int SLOTS       = DIMX * DIMY * CELL_BITS / PORT_WIDTH,
  parameter int SLOT_AW     = SLOTS > 1 ? $clog2(SLOTS) : 1
) (
  input  logic                  clk_in,
  input  logic                  rst,
  cell_array_seq_if.slave       host,
  output logic [SLOT_AW-1:0]    arr_slot,
  output logic                  arr_slot_we,
  output logic [PORT_WIDTH-1:0] arr_ram_data,
  output logic [DIMX-1:0]       arr_in,
  output logic                  arr_clk_en,
  input  logic [DIMX-1:0]       arr_out
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, CAPTURE} state_t;
  state_t                 state;
  logic [SLOT_AW-1:0]     ptr;
  logic [COUNTER_BIT-1:0] cnt;
  logic                   accept;
  logic                   last;
  assign host.cfg_ready = state == LOAD;
  assign accept = host.cfg_ready && host.cfg_valid && !host.abort;
  assign last = ptr == SLOT_AW'(SLOTS - 1);
  always_ff @(posedge clk_in or negedge rst)
    if (!rst) begin
      state         <= IDLE;
      ptr           <= '0;
      cnt           <= '0;
      arr_slot      <= '0;
      arr_slot_we   <= 1'b0;
      arr_ram_data  <= '0;
      arr_in        <= '0;
      arr_clk_en    <= 1'b0;
      host.busy     <= 1'b0;
      host.cfg_done <= 1'b0;
      host.run_done <= 1'b0;
      host.io_out   <= '0;
    end else begin
      arr_slot_we   <= 1'b0;
      host.cfg_done <= 1'b0;
      host.run_done <= 1'b0;
      // abort outranks every in-flight action, including a same-cycle word or capture
      if (state != IDLE && host.abort) begin
        state      <= IDLE;
        host.busy  <= 1'b0;
        arr_clk_en <= 1'b0;
      end else
        case (state)
          IDLE:
            if (host.cfg_start) begin
              state     <= LOAD;
              host.busy <= 1'b1;
              ptr       <= '0;
            end else if (host.run_start) begin
              arr_in     <= host.io_in;
              cnt        <= host.run_cycles;
              host.busy  <= 1'b1;
              state      <= host.run_cycles != '0 ? RUN : CAPTURE;
              arr_clk_en <= host.run_cycles != '0;
            end
          LOAD:
            if (accept) begin
              arr_slot     <= ptr;
              arr_ram_data <= host.cfg_data;
              arr_slot_we  <= 1'b1;
              ptr          <= ptr + 1'b1;
              if (last) begin
                host.cfg_done <= 1'b1;
                host.busy     <= 1'b0;
                state         <= IDLE;
              end
            end
          RUN: begin
            cnt <= cnt - 1'b1;
            if (cnt == COUNTER_BIT'(1)) begin
              state      <= CAPTURE;
              arr_clk_en <= 1'b0;
            end
          end
          CAPTURE: begin
            host.io_out   <= arr_out;
            host.run_done <= 1'b1;
            host.busy     <= 1'b0;
            state         <= IDLE;
          end
        endcase
    end
`ifdef CELL_SEQ_CHECKSUM_EN
  always_ff @(posedge clk_in or negedge rst)
    if (!rst) host.cfg_sum <= '0;
    else if (state == IDLE && host.cfg_start) host.cfg_sum <= '0;
    else if (accept) host.cfg_sum <= host.cfg_sum + host.cfg_data;
`else
  assign host.cfg_sum = '0;
`endif
endmodule

// File: tb/tb_cell_array_seq.sv
// tb_cell_array_seq: table-driven, directed and randomized checks of cell_array_seq
// against a transaction-level model (expected write lists, enable counts, done latency).
module tb_cell_array_seq;
  localparam int DX = 8;
  localparam int PW = 32;
  localparam int CB = 16;
`ifdef CELL_SEQ_CHECKSUM_EN
  localparam bit SUM_EN = 1'b1;
`else
  localparam bit SUM_EN = 1'b0;
`endif
  typedef struct {logic [1:0] slot; logic [PW-1:0] data; logic done;} wr_t;
  typedef struct {int rc; logic [DX-1:0] in; logic [DX-1:0] aout; int exp_en; int exp_done; logic [DX-1:0] exp_out;} run_vec_t;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] arr_slot;
  logic arr_slot_we;
  logic [PW-1:0] arr_ram_data;
  logic [DX-1:0] arr_in;
  logic arr_clk_en;
  logic [DX-1:0] arr_out;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int done_exp = 0;
  logic [PW-1:0] sum_exp = '0;
  logic [PW-1:0] lw[4];
  logic [DX-1:0] io_exp = '0;
  logic [DX-1:0] in_exp = '0;
  wr_t wr_q[$];
  wr_t exp_q[$];
  run_vec_t tbl[5];
  cell_array_seq_if #(.DIMX(DX), .PORT_WIDTH(PW), .COUNTER_BIT(CB)) bus();
  cell_array_seq #(.DIMX(DX), .DIMY(4), .PORT_WIDTH(PW), .CELL_BITS(4), .COUNTER_BIT(CB)) dut (
    .clk_in(clk), .rst(rst_n), .host(bus),
    .arr_slot(arr_slot), .arr_slot_we(arr_slot_we), .arr_ram_data(arr_ram_data),
    .arr_in(arr_in), .arr_clk_en(arr_clk_en), .arr_out(arr_out)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (rst_n) begin
      if (arr_slot_we) wr_q.push_back('{arr_slot, arr_ram_data, bus.cfg_done});
      if (bus.cfg_done) done_cnt++;
    end
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask
  task automatic load(input string name, input int gap, input int abort_j, input bit noise);
    exp_q.delete();
    wr_q.delete();
    bus.cfg_start = 1'b1;
    step;
    bus.cfg_start = 1'b0;
    sum_exp = '0;
    for (int w = 0; w < 4; w++) begin
      int g;
      g = (w == 0) ? 0 : (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(2, 0)) : 0;
      repeat (g) begin
        bus.cfg_valid = 1'b0;
        bus.cfg_start = noise;
        bus.run_start = noise;
        bus.io_in = '1;
        step;
      end
      bus.cfg_start = 1'b0;
      bus.run_start = 1'b0;
      bus.cfg_data = lw[w];
      bus.cfg_valid = 1'b1;
      bus.abort = (w == abort_j);
      chk({name, " ready"}, bus.cfg_ready, 1);
      step;
      bus.cfg_valid = 1'b0;
      bus.abort = 1'b0;
      if (w == abort_j) break;
      sum_exp += lw[w];
      exp_q.push_back('{2'(w), lw[w], w == 3});
    end
    if (abort_j >= 4) done_exp++;
    step;
    step;
    chk({name, " nwrites"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      chk({name, " slot"}, wr_q[i].slot, exp_q[i].slot);
      chk({name, " data"}, wr_q[i].data, exp_q[i].data);
      chk({name, " done_with_write"}, wr_q[i].done, exp_q[i].done);
    end
    chk({name, " busy"}, bus.busy, 0);
    chk({name, " cfg_done count"}, done_cnt, done_exp);
    chk({name, " cfg_sum"}, bus.cfg_sum, SUM_EN ? sum_exp : '0);
    chk({name, " arr_in held"}, arr_in, in_exp);
  endtask
  task automatic run_txn(input string name, input int rc, input logic [DX-1:0] in, input logic [DX-1:0] aout,
                         input int k, input int exp_en, input int exp_done, input logic [DX-1:0] exp_out);
    int en = 0;
    int last = 0;
    int done = 0;
    bus.run_start = 1'b1;
    bus.run_cycles = CB'(rc);
    bus.io_in = in;
    arr_out = aout;
    step;
    bus.run_start = 1'b0;
    bus.io_in = ~in;
    in_exp = in;
    for (int i = 1; i <= rc + 4; i++) begin
      if (arr_clk_en) begin
        en++;
        last = i;
      end
      if (bus.run_done && done == 0) done = i;
      bus.abort = (i == k);
      step;
    end
    bus.abort = 1'b0;
    io_exp = exp_out;
    chk({name, " enable count"}, en, exp_en);
    chk({name, " last enable"}, last, exp_en);
    chk({name, " run_done cycle"}, done, exp_done);
    chk({name, " io_out"}, bus.io_out, io_exp);
    chk({name, " arr_in"}, arr_in, in_exp);
    chk({name, " busy"}, bus.busy, 0);
  endtask
  initial begin
    tbl[0] = '{5, 8'hA5, 8'h3C, 5, 7, 8'h3C};
    tbl[1] = '{0, 8'h0F, 8'h81, 0, 2, 8'h81};
    tbl[2] = '{1, 8'h5A, 8'h42, 1, 3, 8'h42};
    tbl[3] = '{3, 8'hC3, 8'h18, 3, 5, 8'h18};
    tbl[4] = '{9, 8'h01, 8'hFE, 9, 11, 8'hFE};
    {bus.cfg_start, bus.cfg_valid, bus.run_start, bus.abort} = '0;
    bus.cfg_data = '0;
    bus.run_cycles = '0;
    bus.io_in = '0;
    arr_out = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst busy", bus.busy, 0);
    chk("rst cfg_ready", bus.cfg_ready, 0);
    chk("rst arr_clk_en", arr_clk_en, 0);
    chk("rst arr_slot_we", arr_slot_we, 0);
    chk("rst arr_slot", arr_slot, 0);
    chk("rst io_out", bus.io_out, 0);
    chk("rst arr_in", arr_in, 0);
    chk("rst cfg_sum", bus.cfg_sum, 0);
    chk("rst pulses", {bus.cfg_done, bus.run_done}, 0);
    rst_n = 1'b1;
    step;
    lw = '{32'h11, 32'h22, 32'h33, 32'h44};
    load("b2b_load", 0, 4, 1'b0);
    load("toggle_load", 1, 4, 1'b1);
    foreach (tbl[i]) run_txn($sformatf("tbl%0d", i), tbl[i].rc, tbl[i].in, tbl[i].aout, 0,
                             tbl[i].exp_en, tbl[i].exp_done, tbl[i].exp_out);
    run_txn("abort_run", 10, 8'h77, 8'hEE, 3, 3, 0, io_exp);
    load("abort_load", 0, 2, 1'b0);
    load("fresh_load", 0, 4, 1'b0);
    bus.run_start = 1'b1;
    bus.run_cycles = 16'd10;
    bus.io_in = 8'h5A;
    step;
    bus.run_start = 1'b0;
    step;
    step;
    #2 rst_n = 1'b0;
    #1;
    chk("midrun rst arr_clk_en", arr_clk_en, 0);
    chk("midrun rst busy", bus.busy, 0);
    chk("midrun rst arr_in", arr_in, 0);
    chk("midrun rst io_out", bus.io_out, 0);
    chk("midrun rst arr_slot", {arr_slot_we, arr_slot, arr_ram_data}, 0);
    in_exp = '0;
    io_exp = '0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.cfg_start = 1'b1;
    bus.run_start = 1'b1;
    bus.run_cycles = 16'd3;
    bus.io_in = 8'hC3;
    step;
    bus.cfg_start = 1'b0;
    bus.run_start = 1'b0;
    chk("both starts busy", bus.busy, 1);
    chk("both starts in LOAD", bus.cfg_ready, 1);
    chk("both starts no enable", arr_clk_en, 0);
    chk("both starts arr_in", arr_in, 0);
    bus.abort = 1'b1;
    step;
    bus.abort = 1'b0;
    chk("abort idle busy", bus.busy, 0);
    lw = '{32'h1, 32'h2, 32'h3, 32'hFFFF_FFFF};
    load("sum_load", 0, 4, 1'b0);
    chk("sum wraps", bus.cfg_sum, SUM_EN ? 32'h5 : 32'h0);
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(1, 0) == 1) begin
        foreach (lw[i]) lw[i] = $urandom;
        load("rand_load", 2, int'($urandom_range(6, 0)), 1'($urandom_range(1, 0)));
      end else begin
        int rc;
        int k;
        bit ab;
        logic [DX-1:0] in;
        logic [DX-1:0] ao;
        rc = int'($urandom_range(20, 0));
        in = DX'($urandom);
        ao = DX'($urandom);
        k = ($urandom_range(1, 0) == 1) ? int'($urandom_range(rc + 2, 1)) : 0;
        ab = k >= 1 && k <= rc + 1;
        run_txn("rand_run", rc, in, ao, k, ab ? (k < rc ? k : rc) : rc, ab ? 0 : rc + 2, ab ? io_exp : ao);
      end
    end
    run_txn("max_run", 65535, 8'h3C, 8'h99, 0, 65535, 65537, 8'h99);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
